// File: rtl/acc_seq_pkg.sv
// Shared definitions for the accumulator sequencer: state encoding,
// default widths and the iteration-count clamp helper.
package acc_seq_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int CNT_W_DEF    = 7;
    localparam int MAX_ITER_DEF = 99;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Requests above the legal maximum are silently limited to it.
    function automatic int clamp_iter(input int req, input int max_iter);
        int lim;
        if (req > max_iter) begin
            lim = max_iter;
        end else begin
            lim = req;
        end
        return lim;
    endfunction

endpackage

// File: rtl/acc_seq_ctrl.sv
// Sequencer for the sign-magnitude accumulator datapath. Clears the
// datapath, streams exactly N samples into it and hands back the final
// accumulator value over a valid/ready result port.
module acc_seq_ctrl
    import acc_seq_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int MAX_ITER = MAX_ITER_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  n_iter,
    output logic              busy,
    output logic [CNT_W-1:0]  iter_cnt,
    input  logic              x_valid,
    output logic              x_ready,
    input  logic [DATA_W-1:0] x,
    output logic              dp_clr,
    output logic              dp_en,
    output logic [DATA_W-1:0] dp_x,
    input  logic [DATA_W-1:0] dp_y,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              state_r;
    state_t              state_nxt_s;
    logic [CNT_W-1:0]    count_r;
    logic [CNT_W-1:0]    count_req_s;
    logic [CNT_W-1:0]    iter_cnt_r;
    logic                x_ready_r;
    logic                dp_clr_r;
    logic                res_valid_r;
    logic [DATA_W-1:0]   res_r;
    logic                launch_s;
    logic                beat_s;
    logic                last_s;

    // A new run is accepted only from IDLE, and abort always wins over start.
    assign launch_s    = (state_r == ST_IDLE) & start & ~abort;
    assign count_req_s = CNT_W'(clamp_iter(int'(n_iter), MAX_ITER));

    // Handshake flags drop in the abort cycle so no beat or result escapes.
    assign x_ready   = x_ready_r & ~abort;
    assign res_valid = res_valid_r & ~abort;
    assign beat_s    = x_valid & x_ready;
    assign last_s    = ((iter_cnt_r + CNT_ONE) == count_r);

    assign busy      = (state_r != ST_IDLE);
    assign iter_cnt  = iter_cnt_r;
    assign dp_clr    = dp_clr_r;
    assign dp_en     = beat_s;
    assign dp_x      = x;
    assign res       = res_r;

    // Next-state decode; abort returns to IDLE from anywhere.
    always_comb begin
        state_nxt_s = state_r;
        if (abort) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt_s = ST_CLEAR;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    if (count_r == CNT_ZERO) begin
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (beat_s && last_s) begin
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    state_nxt_s = ST_DONE;
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered control outputs, decoded from the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_clr_r    <= 1'b0;
            x_ready_r   <= 1'b0;
            res_valid_r <= 1'b0;
        end else begin
            dp_clr_r    <= (state_nxt_s == ST_CLEAR);
            x_ready_r   <= (state_nxt_s == ST_RUN);
            res_valid_r <= (state_nxt_s == ST_DONE);
        end
    end

    // Latched iteration count and consumed-sample counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r    <= CNT_ZERO;
            iter_cnt_r <= CNT_ZERO;
        end else if (launch_s) begin
            count_r    <= count_req_s;
            iter_cnt_r <= CNT_ZERO;
        end else if (beat_s) begin
            count_r    <= count_r;
            iter_cnt_r <= iter_cnt_r + CNT_ONE;
        end else begin
            count_r    <= count_r;
            iter_cnt_r <= iter_cnt_r;
        end
    end

    // Result capture: dp_y reflects the final beat while in DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_r <= {DATA_W{1'b0}};
        end else if ((state_r == ST_DRAIN) && !abort) begin
            res_r <= dp_y;
        end else begin
            res_r <= res_r;
        end
    end

endmodule
